// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for an 8-digit multiplexed, active-low seven-segment bus.
// Optional SEG_DEC_ERRCNT_EN adds err_cnt_o, a saturating count of bad-glyph and multi-anode accepts.
module seven_seg_scan_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an_in,
    input  logic [6:0]  seg_in,
    output logic [31:0] digits_o,
    output logic [7:0]  digit_seen_o,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic [2:0]  evt_digit_o,
    output logic [3:0]  evt_value_o,
    output logic        evt_bad_o,
    output logic        multi_err_o,
    output logic        ovf_o
`ifdef SEG_DEC_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt_o
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [14:0]      sync_q [SYNC_STAGES];
    logic [14:0]      sample;
    logic [14:0]      prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept_q;
    logic [14:0]      acc_q;

    // The idle bus level is all-high, so the chain clears to ones rather than zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {an_in, seg_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q   <= '1;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            acc_q    <= '1;
        end else begin
            prev_q   <= sample;
            acc_q    <= sample;
            accept_q <= 1'b0;
            if (sample != prev_q) begin
                cnt_q    <= CNT_W'(1);
                accept_q <= (STABLE_CYCLES == 1);
            end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
                cnt_q    <= cnt_q + CNT_W'(1);
                accept_q <= (cnt_q == CNT_W'(STABLE_CYCLES - 1));
            end
        end
    end

    logic [7:0] an_low;
    logic [6:0] seg_pat;
    logic [3:0] dec_code;
    logic       dec_bad;
    logic [2:0] digit_idx;
    logic       multi_low;
    logic       one_low;

    assign an_low    = ~acc_q[14:7];
    assign seg_pat   = acc_q[6:0];
    assign multi_low = (an_low & (an_low - 8'd1)) != 8'd0;
    assign one_low   = (an_low != 8'd0) && !multi_low;

    always_comb begin
        dec_code = 4'hF;
        dec_bad  = 1'b0;
        case (seg_pat)
            7'b0000001: dec_code = 4'h0;
            7'b1001111: dec_code = 4'h1;
            7'b0010010: dec_code = 4'h2;
            7'b0000110: dec_code = 4'h3;
            7'b1001100: dec_code = 4'h4;
            7'b0100100: dec_code = 4'h5;
            7'b1100000: dec_code = 4'h6;
            7'b0001111: dec_code = 4'h7;
            7'b0000000: dec_code = 4'h8;
            7'b0001100: dec_code = 4'h9;
            7'b1110010: dec_code = 4'hA;
            7'b1100110: dec_code = 4'hB;
            7'b1011100: dec_code = 4'hC;
            7'b0110100: dec_code = 4'hD;
            7'b1110000: dec_code = 4'hE;
            7'b1111111: dec_code = 4'hF;
            default:    dec_bad  = 1'b1;
        endcase
    end

    // Anode bit i belongs to digit 7-i.
    always_comb begin
        digit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) digit_idx = 3'(7 - i);
        end
    end

    logic       digit_hit;
    logic       multi_hit;
    logic [3:0] cur_code;
    logic       push;

    assign digit_hit = accept_q && one_low;
    assign multi_hit = accept_q && multi_low;
    assign cur_code  = digits_o[{digit_idx, 2'b00} +: 4];
    assign push      = digit_hit && (!digit_seen_o[digit_idx] || dec_code != cur_code || dec_bad);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_o     <= '0;
            digit_seen_o <= '0;
            multi_err_o  <= 1'b0;
        end else begin
            if (digit_hit) begin
                digits_o[{digit_idx, 2'b00} +: 4] <= dec_code;
                digit_seen_o[digit_idx]           <= 1'b1;
            end
            if (multi_hit) multi_err_o <= 1'b1;
        end
    end

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic [7:0]     head;

    assign full    = count == (PTR_W+1)'(FIFO_DEPTH);
    assign pop     = evt_valid_o && evt_ready_i;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= {digit_idx, dec_code, dec_bad};
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
            if (push && !push_ok) ovf_o <= 1'b1;
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign evt_valid_o = count != '0;
    assign evt_digit_o = evt_valid_o ? head[7:5] : 3'd0;
    assign evt_value_o = evt_valid_o ? head[4:1] : 4'd0;
    assign evt_bad_o   = evt_valid_o ? head[0]   : 1'b0;

`ifdef SEG_DEC_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_o <= '0;
        end else if (((digit_hit && dec_bad) || multi_hit) && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule
